mant_normalize: RTL

Two-stage pipelined normalization stage of the 32-bit FP adder, placed between the significand add/subtract stage and `exp_adjust`. It takes the raw significand sum with its pre-adjust exponent, counts leading zeros, and produces the normalized significand plus the `normalizeAmt` / `right_shift` pair that `exp_adjust` consumes. It uses a valid/ready handshake with full backpressure and sustains one result per cycle.

---
 rtl/mant_normalize_pkg.sv | 9 +
 rtl/mant_normalize_lzc27.sv | 11 +
 rtl/mant_normalize.sv | 97 +++++++++
 3 files changed

// File: rtl/mant_normalize_pkg.sv
// mant_normalize_pkg: shared FP adder widths and significand bit positions.
package mant_normalize_pkg;
    localparam int EXP_WIDTH  = 8;
    localparam int MANT_WIDTH = 23;
    localparam int SUM_WIDTH  = MANT_WIDTH + 5;
    localparam int CARRY_BIT  = 27;
    localparam int HIDDEN_BIT = 26;
    localparam int STICKY_BIT = 0;
endpackage

// File: rtl/mant_normalize_lzc27.sv
// lzc27: leading-zero count of a 27-bit vector; an all-zero input yields 27.
module lzc27 (
    input  logic [26:0] d,
    output logic [4:0]  cnt
);
    always_comb begin
        cnt = 5'd27;
        for (int i = 0; i < 27; i++)
            if (d[i]) cnt = 5'(26 - i);
    end
endmodule

// File: rtl/mant_normalize.sv
// mant_normalize: two-stage significand normalizer with valid/ready backpressure.
// NORM_STICKY_EN folds the dropped sticky bit into bit 0 on a right shift.
module mant_normalize
    import mant_normalize_pkg::*;
#(
    parameter int EXP_WIDTH  = mant_normalize_pkg::EXP_WIDTH,
    parameter int MANT_WIDTH = mant_normalize_pkg::MANT_WIDTH,
    parameter int SUM_WIDTH  = MANT_WIDTH + 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_WIDTH-1:0] in_exp,
    input  logic [SUM_WIDTH-1:0] in_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [EXP_WIDTH-1:0] exp_adjust_pre,
    output logic [5:0]           normalizeAmt,
    output logic                 right_shift,
    output logic [SUM_WIDTH-1:0] out_mant,
    output logic                 out_zero
);
    logic                 s1_valid, s1_sign, s1_zero;
    logic [EXP_WIDTH-1:0] s1_exp;
    logic [SUM_WIDTH-1:0] s1_sum;
    logic [4:0]           s1_lzc, lzc;
    logic                 s1_adv, s2_adv;

    assign s2_adv   = !out_valid | out_ready;
    assign s1_adv   = !s1_valid | s2_adv;
    assign in_ready = s1_adv;

    lzc27 u_lzc (.d(in_sum[HIDDEN_BIT:0]), .cnt(lzc));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_exp   <= '0;
            s1_sum   <= '0;
            s1_lzc   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_zero <= in_sum == '0;
                s1_exp  <= in_exp;
                s1_sum  <= in_sum;
                s1_lzc  <= lzc;
            end
        end
    end

    logic                 carry, sticky;
    logic [EXP_WIDTH-1:0] lim;
    logic [4:0]           amt;
    logic [SUM_WIDTH-1:0] n_mant;
    logic [5:0]           n_amt;

    assign carry = s1_sum[CARRY_BIT];
    assign lim   = s1_exp - EXP_WIDTH'(1);
    // Clamp so the exponent never drops below 1; the result goes denormal instead.
    assign amt   = (s1_exp == '0) ? 5'd0 : (EXP_WIDTH'(s1_lzc) < lim) ? s1_lzc : lim[4:0];
`ifdef NORM_STICKY_EN
    assign sticky = s1_sum[1] | s1_sum[STICKY_BIT];
`else
    assign sticky = s1_sum[1];
`endif
    assign n_mant = s1_zero ? '0 : carry ? {1'b0, s1_sum[SUM_WIDTH-1:2], sticky} : s1_sum << amt;
    assign n_amt  = s1_zero ? 6'd0 : carry ? 6'd1 : {1'b0, amt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_sign       <= 1'b0;
            exp_adjust_pre <= '0;
            normalizeAmt   <= '0;
            right_shift    <= 1'b0;
            out_mant       <= '0;
            out_zero       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign       <= s1_sign;
                exp_adjust_pre <= s1_exp;
                normalizeAmt   <= n_amt;
                right_shift    <= !s1_zero & carry;
                out_mant       <= n_mant;
                out_zero       <= s1_zero;
            end
        end
    end
endmodule
